// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory between the MEM stage and write-back: registered read with valid strobe,
// selectable read-during-write, out-of-range flag, and a one-word-per-cycle init engine loading data[i]=i.
module data_memory_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 32,
  parameter bit RDW_MODE = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  output logic              readvalid,
  output logic              busy,
  output logic              addr_err
);

  localparam int               CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] readdata_d;
  logic              readvalid_q;
  logic              readvalid_d;
  logic              addr_err_q;
  logic              addr_err_d;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic              accept;
  logic [CNT_W-1:0]  mem_idx;
  logic              wr_en;
  logic [CNT_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_dat;

  // Full-width compare: an address beyond DEPTH never aliases onto a low entry.
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign mem_idx  = address[CNT_W-1:0];
  assign accept   = (state_q == S_READY) && !RESET && (memread || memwrite);

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = mem_idx;
    wr_dat = writedata;
    if (!RESET) begin
      if (state_q == S_INIT) begin
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        wr_dat = DATA_W'(cnt_q);
      end else if (memwrite && in_range) begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    readdata_d  = readdata_q;
    readvalid_d = 1'b0;
    addr_err_d  = 1'b0;
    if (accept) begin
      if (!in_range) begin
        addr_err_d = 1'b1;
      end else if (memread) begin
        readvalid_d = 1'b1;
        readdata_d  = (RDW_MODE && memwrite) ? writedata : mem_q[mem_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      readdata_q  <= '0;
      readvalid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      readdata_q  <= readdata_d;
      readvalid_q <= readvalid_d;
      addr_err_q  <= addr_err_d;
      case (state_q)
        S_INIT: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign readdata  = readdata_q;
  assign readvalid = readvalid_q;
  assign busy      = busy_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three instances (RDW old-data, RDW write-through, 16b/512-deep) share one stimulus stream.
module tb_data_memory_ctrl;

  typedef struct {
    int cyc;
    bit rv;
    bit ae;
    int rd;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst_s = 1'b1;
  logic        rd_s = 1'b0;
  logic        wr_s = 1'b0;
  logic [9:0]  addr_s = '0;
  logic [15:0] wd_s = '0;

  logic [7:0]  rdat0, rdat1;
  logic [15:0] rdat2;
  logic        rv0, rv1, rv2, bz0, bz1, bz2, ae0, ae1, ae2;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  bit checking = 1'b0;

  int depth[3] = '{32, 32, 512};
  int amask[3] = '{255, 255, 1023};
  int dmask[3] = '{255, 255, 65535};
  bit rdw[3]   = '{1'b0, 1'b1, 1'b0};

  int   mem[3][512];
  int   left[3];
  int   held[3];
  bit   xbusy[3];
  exp_t sbq[3][$];

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32), .RDW_MODE(1'b0)) u_dut0 (
    .CLK(CLK), .RESET(rst_s), .address(addr_s[7:0]), .writedata(wd_s[7:0]),
    .memread(rd_s), .memwrite(wr_s), .readdata(rdat0), .readvalid(rv0), .busy(bz0), .addr_err(ae0)
  );

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(32), .RDW_MODE(1'b1)) u_dut1 (
    .CLK(CLK), .RESET(rst_s), .address(addr_s[7:0]), .writedata(wd_s[7:0]),
    .memread(rd_s), .memwrite(wr_s), .readdata(rdat1), .readvalid(rv1), .busy(bz1), .addr_err(ae1)
  );

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .RDW_MODE(1'b0)) u_dut2 (
    .CLK(CLK), .RESET(rst_s), .address(addr_s), .writedata(wd_s),
    .memread(rd_s), .memwrite(wr_s), .readdata(rdat2), .readvalid(rv2), .busy(bz2), .addr_err(ae2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, c, cycle, act, exp);
    end
  endtask

  // Reference behaviour per instance, applied once per rising edge with the sampled inputs.
  task automatic model_edge(input int c, input bit r, input bit rd, input bit wr, input int a_in, input int wd_in);
    int   a;
    int   wd;
    exp_t e;
    a  = a_in & amask[c];
    wd = wd_in & dmask[c];
    if (r) begin
      left[c]  = depth[c];
      held[c]  = 0;
      xbusy[c] = 1'b1;
      return;
    end
    if (left[c] > 0) begin
      left[c]--;
      if (left[c] == 0) begin
        for (int i = 0; i < depth[c]; i++) mem[c][i] = i & dmask[c];
      end
      xbusy[c] = (left[c] > 0);
      return;
    end
    xbusy[c] = 1'b0;
    if ((rd || wr) && a >= depth[c]) begin
      e.cyc = cycle; e.rv = 1'b0; e.ae = 1'b1; e.rd = held[c];
      sbq[c].push_back(e);
    end else begin
      if (rd) begin
        held[c] = (rdw[c] && wr) ? wd : mem[c][a];
        e.cyc = cycle; e.rv = 1'b1; e.ae = 1'b0; e.rd = held[c];
        sbq[c].push_back(e);
      end
      if (wr) mem[c][a] = wd;
    end
  endtask

  task automatic mon(input int c, input logic rv, input logic ae, input logic [15:0] rd, input logic bz);
    exp_t e;
    while (sbq[c].size() > 0 && sbq[c][0].cyc < cycle) begin
      e = sbq[c].pop_front();
      chk("pulse_missing_at_cycle", c, cycle, e.cyc);
    end
    if (rv !== 1'b0 || ae !== 1'b0) begin
      if (sbq[c].size() == 0) begin
        chk("unexpected_pulse", c, {rv, ae}, 0);
      end else begin
        e = sbq[c].pop_front();
        chk("pulse_cycle", c, cycle, e.cyc);
        chk("readvalid", c, rv, e.rv);
        chk("addr_err", c, ae, e.ae);
        if (e.rv) chk("readdata", c, rd, e.rd);
      end
    end
    chk("readdata_hold", c, rd, held[c]);
    chk("busy", c, bz, xbusy[c]);
  endtask

  always @(negedge CLK) begin
    if (checking) begin
      mon(0, rv0, ae0, {8'h00, rdat0}, bz0);
      mon(1, rv1, ae1, {8'h00, rdat1}, bz1);
      mon(2, rv2, ae2, rdat2, bz2);
    end
  end

  task automatic step(input bit r, input bit rd, input bit wr, input int a, input int wd);
    rst_s  = r;
    rd_s   = rd;
    wr_s   = wr;
    addr_s = a[9:0];
    wd_s   = wd[15:0];
    @(posedge CLK);
    cycle++;
    for (int c = 0; c < 3; c++) model_edge(c, r, rd, wr, a, wd);
    if (r) checking = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      left[c] = 0; held[c] = 0; xbusy[c] = 1'b0;
    end
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);

    // Requests during init are ignored; a reset at init cycle 20 restarts the sequence.
    for (int i = 0; i < 20; i++) step(1'b0, i == 7, i == 4, 3, 'h77);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    idle(32);

    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 17, 0);
    step(1'b0, 1'b1, 1'b0, 31, 0);
    step(1'b0, 1'b1, 1'b0, 3, 0);
    step(1'b0, 1'b0, 1'b1, 5, 'hA5);
    step(1'b0, 1'b1, 1'b0, 5, 0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 9, 0);
    step(1'b0, 1'b1, 1'b1, 9, 'h3C);
    step(1'b0, 1'b1, 1'b0, 9, 0);
    step(1'b0, 1'b0, 1'b1, 32, 'hFF);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 31, 0);
    step(1'b0, 1'b1, 1'b0, 200, 0);
    idle(2);

    idle(520);
    step(1'b0, 1'b1, 1'b0, 511, 0);
    step(1'b0, 1'b1, 1'b0, 300, 0);
    step(1'b0, 1'b0, 1'b1, 400, 'hBEEF);
    step(1'b0, 1'b1, 1'b0, 400, 0);
    step(1'b0, 1'b1, 1'b0, 512, 0);
    step(1'b0, 1'b0, 1'b1, 512, 'h1234);
    step(1'b0, 1'b1, 1'b0, 1023, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      int a;
      int k;
      k = int'($urandom_range(0, 99));
      if (k < 60)      a = int'($urandom_range(0, 40));
      else if (k < 80) a = int'($urandom_range(0, 1023));
      else             a = int'($urandom_range(500, 520));
      step($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           a, int'($urandom_range(0, 65535)));
    end
    idle(3);

    for (int c = 0; c < 3; c++) chk("scoreboard_drained", c, sbq[c].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the 8-bit, 32-entry data memory. Generalised width/depth, registered read with valid strobe, configurable read-during-write, out-of-range address detection.
- Reset pattern data[i]=i is now loaded by a sequential init engine: one word per cycle, all DEPTH entries including the last.
- Sits between the CPU datapath's MEM stage and the register write-back mux.

Parameters:
- DATA_W, 8: word width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 32: number of words. Legal range is 2 <= DEPTH <= 2**ADDR_W.
- RDW_MODE, 0: same-cycle read and write to the same address. 0 returns the old data; 1 returns writedata (write-through).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address.
- writedata  in  DATA_W  write data.
- memread  in  1  read request, sampled at the clock edge.
- memwrite  in  1  write request, sampled at the clock edge.
- readdata  out  DATA_W  registered read data; holds its value between reads.
- readvalid  out  1  one-cycle pulse: readdata was updated this cycle.
- busy  out  1  high while the init engine runs; requests are ignored.
- addr_err  out  1  one-cycle pulse: a request used address >= DEPTH.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, sampled only at the rising edge of CLK.
- Reset values (after an edge with RESET=1):
  - state=INIT, init counter cnt=0.
  - readdata=0, readvalid=0, addr_err=0, busy=1.
  - Memory contents are not cleared by reset itself; the init engine overwrites them.
- FSM states: INIT, READY.
- INIT:
  - Each edge with RESET=0 writes data[cnt] = cnt mod 2**DATA_W, then cnt increments.
  - On the edge that writes cnt=DEPTH-1, state goes to READY and busy goes to 0.
  - busy is high for exactly DEPTH cycles after RESET deasserts.
  - memread and memwrite are ignored during INIT: no write, no readvalid, no addr_err.
- READY, read: memread=1 and address<DEPTH -> at the next edge readdata=data[address] and readvalid=1. Read latency is one cycle.
- READY, write: memwrite=1 and address<DEPTH -> data[address]=writedata at the edge. The stored word is visible to reads issued from the next cycle onward.
- Simultaneous read and write:
  - Same address: RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns writedata. The write occurs in both modes.
  - Different addresses: both operations proceed independently.
- Idle: memread=0 -> readvalid=0 and readdata holds its last value. memwrite=0 -> no write.
- Out-of-range: address >= DEPTH with memread or memwrite set ->
  - write suppressed;
  - readdata held, readvalid=0;
  - addr_err=1 for one cycle.
- Pulse width: readvalid and addr_err are high for exactly one cycle per accepted request, never stretched. Back-to-back reads give one pulse per cycle.
- Reset during INIT or READY: state returns to INIT, cnt returns to 0, and the full init sequence re-runs. In-flight reads produce no readvalid.
- Width rules:
  - Init value is cnt truncated to DATA_W bits (DEPTH=512, DATA_W=8 -> entry 300 holds 44).
  - address is compared at full ADDR_W width, with no aliasing.
  - cnt is wide enough to hold DEPTH-1.

Test Plan:
- Reset then init: pulse RESET 1 cycle with defaults -> busy=1 for exactly 32 cycles. Then read addresses 0, 17 and 31 -> readdata 0, 17, 31, each with readvalid one cycle after its request.
- Write/read: write 0xA5 to address 5, then read address 5 on the next cycle -> readdata=0xA5 with readvalid. Idle for 3 cycles -> readdata stays 0xA5, readvalid=0.
- Read-during-write: data[9]=9, then memread=memwrite=1, address 9, writedata 0x3C. RDW_MODE=0 -> readdata=9; RDW_MODE=1 -> readdata=0x3C. A following read returns 0x3C in both modes.
- Out-of-range: write 0xFF to address 32 (DEPTH=32) -> addr_err pulses, no memory changes (spot-check addresses 0 and 31). Read address 200 -> addr_err=1, readvalid=0, readdata unchanged.
- Busy lockout and mid-init reset:
  - Write 0x77 to address 3 at cycle 5 of INIT -> ignored; after init, data[3]=3.
  - Assert RESET at init cycle 20 -> busy stays high for a further 32 full cycles.
- Parametrised: DATA_W=16, ADDR_W=10, DEPTH=512 -> after init data[511]=511; write 0xBEEF to address 400 and read it back -> 0xBEEF; address 512 -> addr_err.
